// File: rtl/soc_system_sysid_pkg.sv
// Shared definitions for the system ID slave and its upstream checker.
// Regenerate both together so the expected words stay in step with the slave contents.
package soc_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ID   = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_RD_TS   = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_FIN     = 3'd5
  } sysid_chk_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'hACD51302;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'h64C5726D;

  // Word select driven on the bus for a given checker state
  function automatic logic sysid_addr_for(input sysid_chk_state_t s);
    logic addr;
    case (s)
      ST_RD_TS, ST_WAIT_TS: addr = SYSID_ADDR_TS;
      default:              addr = SYSID_ADDR_ID;
    endcase
    return addr;
  endfunction

  // True for the states that issue a read request
  function automatic logic sysid_is_req(input sysid_chk_state_t s);
    logic req;
    case (s)
      ST_RD_ID, ST_RD_TS: req = 1'b1;
      default:            req = 1'b0;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp words
// and flags a stale or mismatched bitstream; all outputs are registered.
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  sysid_chk_state_t state_r, state_nx_s;
  logic [7:0]  tmo_cnt_r, tmo_cnt_nx_s;
  logic [31:0] id_value_r, id_value_nx_s;
  logic [31:0] ts_value_r, ts_value_nx_s;
  logic        auto_pend_r;
  logic        avm_read_r, avm_address_r;
  logic        busy_r, done_r;
  logic        id_ok_r, ts_ok_r, timeout_r;
  logic        accept_s, tmo_last_s, id_phase_s;
  logic        seq_start_s, timeout_hit_s;

  assign accept_s   = avm_read_r && !avm_waitrequest;
  assign tmo_last_s = (tmo_cnt_r == TMO_LAST);
  assign id_phase_s = (state_r == ST_RD_ID) || (state_r == ST_WAIT_ID);

  // Next-state selection, per-transaction timeout counting and word capture
  always_comb begin
    state_nx_s    = state_r;
    tmo_cnt_nx_s  = tmo_cnt_r;
    id_value_nx_s = id_value_r;
    ts_value_nx_s = ts_value_r;
    seq_start_s   = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start || auto_pend_r) begin
          state_nx_s    = ST_RD_ID;
          tmo_cnt_nx_s  = 8'd0;
          id_value_nx_s = 32'd0;
          ts_value_nx_s = 32'd0;
          seq_start_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RD_ID, ST_RD_TS, ST_WAIT_ID, ST_WAIT_TS: begin
        // Data wins over a timeout landing in the same cycle
        if (avm_readdatavalid && (accept_s || !sysid_is_req(state_r))) begin
          tmo_cnt_nx_s = 8'd0;
          if (id_phase_s) begin
            id_value_nx_s = avm_readdata;
            state_nx_s    = ST_RD_TS;
          end else begin
            ts_value_nx_s = avm_readdata;
            state_nx_s    = ST_FIN;
          end
        end else if (tmo_last_s) begin
          tmo_cnt_nx_s  = tmo_cnt_r + 8'd1;
          timeout_hit_s = 1'b1;
          state_nx_s    = ST_FIN;
        end else if (accept_s) begin
          tmo_cnt_nx_s = tmo_cnt_r + 8'd1;
          state_nx_s   = id_phase_s ? ST_WAIT_ID : ST_WAIT_TS;
        end else begin
          tmo_cnt_nx_s = tmo_cnt_r + 8'd1;
        end
      end
      ST_FIN: begin
        state_nx_s   = ST_IDLE;
        tmo_cnt_nx_s = 8'd0;
      end
      default: begin
        state_nx_s   = ST_IDLE;
        tmo_cnt_nx_s = 8'd0;
      end
    endcase
  end

  // State, captured words and bus request registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      tmo_cnt_r     <= 8'd0;
      id_value_r    <= 32'd0;
      ts_value_r    <= 32'd0;
      auto_pend_r   <= AUTO_START;
      avm_read_r    <= 1'b0;
      avm_address_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      tmo_cnt_r     <= tmo_cnt_nx_s;
      id_value_r    <= id_value_nx_s;
      ts_value_r    <= ts_value_nx_s;
      auto_pend_r   <= 1'b0;
      avm_read_r    <= sysid_is_req(state_nx_s);
      avm_address_r <= sysid_addr_for(state_nx_s);
      busy_r        <= (state_nx_s != ST_IDLE);
      done_r        <= (state_nx_s == ST_FIN);
    end
  end

  // Sticky verdicts: cleared when a sequence starts, settled as FIN is entered
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      id_ok_r   <= 1'b0;
      ts_ok_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else if (seq_start_s) begin
      id_ok_r   <= 1'b0;
      ts_ok_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else if (state_nx_s == ST_FIN) begin
      if (timeout_hit_s) begin
        id_ok_r   <= 1'b0;
        ts_ok_r   <= 1'b0;
        timeout_r <= 1'b1;
      end else begin
        id_ok_r   <= (id_value_nx_s == EXPECTED_ID);
        ts_ok_r   <= (ts_value_nx_s == EXPECTED_TS) || !CHECK_TS;
        timeout_r <= 1'b0;
      end
    end
  end

  assign avm_address = avm_address_r;
  assign avm_read    = avm_read_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign id_ok       = id_ok_r;
  assign ts_ok       = ts_ok_r;
  assign timeout     = timeout_r;
  assign id_value    = id_value_r;
  assign ts_value    = ts_value_r;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Directed bench for soc_system_sysid_checker: a configurable sysid slave model
// serves two checker instances (CHECK_TS = 1 and 0) running in lockstep.
module tb_soc_system_sysid_checker;
  import soc_system_sysid_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, start;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;

  logic        a_avm_address, a_avm_read, a_busy, a_done, a_id_ok, a_ts_ok, a_timeout;
  logic [31:0] a_id_value, a_ts_value;
  logic        b_avm_address, b_avm_read, b_busy, b_done, b_id_ok, b_ts_ok, b_timeout;
  logic [31:0] b_id_value, b_ts_value;

  soc_system_sysid_checker #(.CHECK_TS(1'b1), .TIMEOUT_CYCLES(8), .AUTO_START(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(a_avm_address), .avm_read(a_avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata), .busy(a_busy), .done(a_done),
    .id_ok(a_id_ok), .ts_ok(a_ts_ok), .timeout(a_timeout),
    .id_value(a_id_value), .ts_value(a_ts_value));

  soc_system_sysid_checker #(.CHECK_TS(1'b0), .TIMEOUT_CYCLES(8), .AUTO_START(1'b1)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(b_avm_address), .avm_read(b_avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata), .busy(b_busy), .done(b_done),
    .id_ok(b_id_ok), .ts_ok(b_ts_ok), .timeout(b_timeout),
    .id_value(b_id_value), .ts_value(b_ts_value));

  int          cfg_stall, cfg_lat;
  bit          cfg_never, late_beat;
  logic [31:0] cfg_id, cfg_ts;
  int          stall_cnt, pend;
  logic        pend_addr, stall_addr;
  bit          was_stalled, bus_err;
  int          done_cnt;
  int          n_checks, n_pass;
  int          lat, d0;

  // Slave model: decides each cycle's response at the falling edge from dut_a's request
  initial begin
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
    stall_cnt = 0; pend = 0; pend_addr = 1'b0; stall_addr = 1'b0;
    was_stalled = 1'b0; bus_err = 1'b0;
    forever begin
      @(negedge clock);
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
      if (!reset_n) begin
        stall_cnt = 0; pend = 0; was_stalled = 1'b0;
      end else begin
        if (was_stalled && (!a_avm_read || a_avm_address != stall_addr)) bus_err = 1'b1;
        was_stalled = 1'b0;
        if (late_beat) begin
          avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF;
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = pend_addr ? cfg_ts : cfg_id;
          end
        end else if (a_avm_read) begin
          if (stall_cnt < cfg_stall) begin
            avm_waitrequest = 1'b1; stall_cnt++;
            was_stalled = 1'b1; stall_addr = a_avm_address;
          end else begin
            stall_cnt = 0;
            if (!cfg_never) begin
              if (cfg_lat == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = a_avm_address ? cfg_ts : cfg_id;
              end else begin
                pend = cfg_lat; pend_addr = a_avm_address;
              end
            end
          end
        end
      end
    end
  end

  // Count done pulses of dut_a
  initial begin
    done_cnt = 0;
    forever begin
      @(posedge clock); #1;
      if (a_done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Counts edges from the one that samples start / reset release; clears start after it
  task automatic wait_done(input int budget, output int l);
    l = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (a_done) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    repeat (2) @(negedge clock);
    start = 1'b1;
  endtask

  task automatic reset_release();
    @(negedge clock); reset_n = 1'b0;
    repeat (2) @(negedge clock); reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    reset_n = 1'b0; start = 1'b0; late_beat = 1'b0;
    cfg_stall = 0; cfg_lat = 0; cfg_never = 1'b0;
    cfg_id = 32'hACD51302; cfg_ts = 32'h64C5726D;
    repeat (3) @(negedge clock);
    chk("reset_flags", 32'({a_busy, a_done, a_avm_read, a_avm_address, a_id_ok, a_ts_ok, a_timeout}), 32'd0);
    chk("reset_id_value", a_id_value, 32'd0);

    // Auto-start against a zero-wait, same-cycle-data slave
    reset_n = 1'b1;
    wait_done(20, lat);
    chk("auto_done_cycle", 32'(lat), 32'd3);
    chk("auto_ok_flags", 32'({a_id_ok, a_ts_ok, a_timeout}), 32'b110);
    chk("auto_id_value", a_id_value, 32'hACD51302);
    chk("auto_ts_value", a_ts_value, 32'h64C5726D);
    // start raised during FIN is dropped
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    chk("fin_start_ignored", 32'(a_busy), 32'd0);

    // Wrong ID word
    cfg_id = 32'h00000001;
    pulse_start();
    wait_done(20, lat);
    chk("badid_done_cycle", 32'(lat), 32'd3);
    chk("badid_ok_flags", 32'({a_id_ok, a_ts_ok, a_timeout}), 32'b010);
    chk("badid_id_value", a_id_value, 32'h00000001);

    // Timestamp off by one: fails only when timestamps are checked
    cfg_id = 32'hACD51302; cfg_ts = 32'h64C5726E;
    pulse_start();
    wait_done(20, lat);
    chk("badts_a_flags", 32'({a_id_ok, a_ts_ok}), 32'b10);
    chk("badts_b_ts_ok", 32'(b_ts_ok), 32'd1);
    chk("badts_b_ts_value", b_ts_value, 32'h64C5726E);

    // Three stall cycles per request, data one cycle after acceptance
    cfg_ts = 32'h64C5726D; cfg_stall = 3; cfg_lat = 1;
    reset_release();
    wait_done(40, lat);
    chk("stall_done_cycle", 32'(lat), 32'd11);
    chk("stall_ok_flags", 32'({a_id_ok, a_ts_ok, a_timeout}), 32'b110);

    // start pulsed while busy must not queue a second run
    d0 = done_cnt;
    repeat (2) @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (30) @(posedge clock); #1;
    chk("midstart_one_done", 32'(done_cnt - d0), 32'd1);
    chk("midstart_idle", 32'(a_busy), 32'd0);

    // Slave never returns data: timeout after 8 cycles
    cfg_stall = 0; cfg_lat = 0; cfg_never = 1'b1;
    reset_release();
    wait_done(40, lat);
    pulse_start();
    wait_done(40, lat);
    chk("tmo_done_cycle", 32'(lat), 32'd9);
    chk("tmo_flags", 32'({a_id_ok, a_ts_ok, a_timeout}), 32'b001);
    chk("tmo_b_flags", 32'({b_id_ok, b_ts_ok, b_timeout}), 32'b001);
    late_beat = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1; late_beat = 1'b0;
    chk("late_beat_id_value", a_id_value, 32'd0);
    chk("late_beat_ts_value", a_ts_value, 32'd0);

    // Reset asserted while waiting for the timestamp beat
    cfg_never = 1'b0; cfg_lat = 3;
    reset_release();
    d0 = done_cnt;
    repeat (6) @(posedge clock); #1;
    chk("wait_ts_bus", 32'({a_busy, a_avm_read, a_avm_address}), 32'b101);
    chk("wait_ts_id_value", a_id_value, 32'hACD51302);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("midreset_flags", 32'({a_busy, a_done, a_avm_read, a_avm_address, a_id_ok, a_ts_ok, a_timeout}), 32'd0);
    chk("midreset_id_value", a_id_value, 32'd0);
    repeat (3) @(posedge clock); #1;
    chk("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    cfg_lat = 0;
    @(negedge clock); reset_n = 1'b1;
    wait_done(20, lat);
    chk("post_reset_done_cycle", 32'(lat), 32'd3);
    pulse_start();
    wait_done(20, lat);
    chk("fresh_start_done_cycle", 32'(lat), 32'd3);
    chk("fresh_start_flags", 32'({a_id_ok, a_ts_ok, a_timeout}), 32'b110);

    chk("bus_stable_when_stalled", 32'(bus_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
